// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter that gives NREQ requesters sequenced
// write access to one shared bank of WIDTH JK flip-flop cells.
// A command is accepted in IDLE, applied in APPLY, then COOL cycles of
// lock-out follow before the next accept.
// Optional feature macro: JK_SR_GUARD_EN. When it is defined, a command latched
// with sr_mode=1 that has J=K=1 on any bit is rejected: the bank is left as it
// was and err pulses for one cycle.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int COOL  = 1
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_j,
  input  logic [NREQ*WIDTH-1:0]    req_k,
  input  logic                     sr_mode,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_bar,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     err
);

  localparam int GW = $clog2(NREQ);
  // The counter is loaded with COOL-1 so that exactly COOL cycles are spent in COOL.
  localparam logic [3:0] COOL_LOAD = (COOL > 0) ? 4'(COOL - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [GW-1:0]    r_ptr;
  logic [GW-1:0]    r_grant;
  logic [WIDTH-1:0] r_cmd_j;
  logic [WIDTH-1:0] r_cmd_k;
  logic             r_cmd_sr;
  logic [3:0]       r_cool_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_bar;

  logic             w_any;
  logic [GW-1:0]    w_win;
  logic             w_accept;
  logic             w_reject;
  logic [WIDTH-1:0] w_q_nxt;

`ifdef JK_SR_GUARD_EN
  // An SR command with S=R=1 on any bit is illegal; the whole word is dropped.
  assign w_reject = r_cmd_sr & (|(r_cmd_j & r_cmd_k));
`else
  // Without the guard sr_mode has no effect; J=K=1 always toggles.
  assign w_reject = 1'b0;
  logic w_unused_sr;
  assign w_unused_sr = r_cmd_sr;
`endif

  // Round-robin search: first valid requester at or after r_ptr, wrapping modulo NREQ.
  always_comb begin : p_arb
    int idx;
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    w_any = 1'b0;
    w_win = '0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(r_ptr) + off) % NREQ;
      if (!w_any && req_valid[idx]) begin
        w_any = 1'b1;
        w_win = GW'(idx);
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_any;

  // FSM state register.
  always_ff @(posedge clock or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_APPLY;
      S_APPLY: w_state_nxt = (COOL > 0) ? S_COOL : S_IDLE;
      S_COOL:  if (r_cool_cnt == 4'd0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: one-hot ready only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    busy      = (r_state != S_IDLE);
    err       = 1'b0;
    if ((r_state == S_IDLE) && rst && w_any) req_ready = NREQ'(1) << w_win;
    if (r_state == S_APPLY) err = w_reject;
  end

  // Latch the accepted command and advance the round-robin pointer.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_cmd_j  <= '0;
      r_cmd_k  <= '0;
      r_cmd_sr <= 1'b0;
      r_grant  <= '0;
      r_ptr    <= '0;
    end else if (w_accept) begin
      r_cmd_j  <= req_j[int'(w_win)*WIDTH +: WIDTH];
      r_cmd_k  <= req_k[int'(w_win)*WIDTH +: WIDTH];
      r_cmd_sr <= sr_mode;
      r_grant  <= w_win;
      r_ptr    <= GW'((int'(w_win) + 1) % NREQ);
    end
  end

  // Lock-out counter: loaded in APPLY, counts down while in COOL.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_cool_cnt <= 4'd0;
    end else if (r_state == S_APPLY) begin
      r_cool_cnt <= COOL_LOAD;
    end else if ((r_state == S_COOL) && (r_cool_cnt != 4'd0)) begin
      r_cool_cnt <= r_cool_cnt - 4'd1;
    end
  end

  // Per-bit JK next value from the latched command: hold / clear / set / toggle.
  always_comb begin
    w_q_nxt = r_q;
    for (int b = 0; b < WIDTH; b++) begin
      case ({r_cmd_j[b], r_cmd_k[b]})
        2'b00:   w_q_nxt[b] = r_q[b];
        2'b01:   w_q_nxt[b] = 1'b0;
        2'b10:   w_q_nxt[b] = 1'b1;
        default: w_q_nxt[b] = ~r_q[b];
      endcase
    end
  end

  // Bank update in APPLY; q_bar is registered with q so the two never disagree.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_q     <= '0;
      r_q_bar <= '1;
    end else if ((r_state == S_APPLY) && !w_reject) begin
      r_q     <= w_q_nxt;
      r_q_bar <= ~w_q_nxt;
    end
  end

  assign q        = r_q;
  assign q_bar    = r_q_bar;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed testbench for jk_bank_arbiter. Instance dut uses COOL=1, instance
// dut0 uses COOL=0. Inputs are driven on the falling edge, outputs sampled 1 ns later.
module tb_jk_bank_arbiter;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;

  logic [3:0]  valid, ready;
  logic [31:0] j, k;
  logic        sr;
  logic [7:0]  q, qb;
  logic        busy, err;
  logic [1:0]  gid;

  logic [3:0]  valid0, ready0;
  logic [31:0] j0, k0;
  logic        sr0;
  logic [7:0]  q0, qb0;
  logic        busy0, err0;
  logic [1:0]  gid0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .COOL(1)) dut (
    .clock(clock), .rst(rst), .req_valid(valid), .req_ready(ready),
    .req_j(j), .req_k(k), .sr_mode(sr), .q(q), .q_bar(qb),
    .busy(busy), .grant_id(gid), .err(err)
  );

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .COOL(0)) dut0 (
    .clock(clock), .rst(rst), .req_valid(valid0), .req_ready(ready0),
    .req_j(j0), .req_k(k0), .sr_mode(sr0), .q(q0), .q_bar(qb0),
    .busy(busy0), .grant_id(gid0), .err(err0)
  );

  task automatic test_reset();
    valid = 4'hF; j = '0; k = '0; sr = 1'b0;
    valid0 = 4'hF; j0 = '0; k0 = '0; sr0 = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_vec++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL rst_ready: got %b want %b", ready, 4'b0000); end
    n_vec++; if (q !== 8'h00) begin n_bad++; $display("FAIL rst_q: got %h want %h", q, 8'h00); end
    n_vec++; if (qb !== 8'hFF) begin n_bad++; $display("FAIL rst_qbar: got %h want %h", qb, 8'hFF); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (gid !== 2'd0) begin n_bad++; $display("FAIL rst_gid: got %0d want 0", gid); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_vec++; if (ready0 !== 4'b0000) begin n_bad++; $display("FAIL rst_ready0: got %b want %b", ready0, 4'b0000); end
    n_vec++; if (qb0 !== 8'hFF) begin n_bad++; $display("FAIL rst_qbar0: got %h want %h", qb0, 8'hFF); end
    @(negedge clock);
    valid = '0; valid0 = '0;
    rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_rel_busy: got %b want 0", busy); end
  endtask

  // Two commands from req0 with COOL=1; checks latency and the 3-cycle accept spacing.
  task automatic test_single();
    @(negedge clock);
    valid = 4'b0001; j[7:0] = 8'hF0; k[7:0] = 8'h0F; sr = 1'b0;
    #1;
    n_vec++; if (ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready1: got %b want %b", ready, 4'b0001); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    @(negedge clock);
    valid = '0;
    #1;
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_apply: got %b want 1", busy); end
    n_vec++; if (q !== 8'h00) begin n_bad++; $display("FAIL single_q_apply: got %h want %h", q, 8'h00); end
    n_vec++; if (gid !== 2'd0) begin n_bad++; $display("FAIL single_gid: got %0d want 0", gid); end
    @(negedge clock);
    #1;
    n_vec++; if (q !== 8'hF0) begin n_bad++; $display("FAIL single_q1: got %h want %h", q, 8'hF0); end
    n_vec++; if (qb !== 8'h0F) begin n_bad++; $display("FAIL single_qbar1: got %h want %h", qb, 8'h0F); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_cool: got %b want 1", busy); end
    valid = 4'b0001; j[7:0] = 8'hFF; k[7:0] = 8'hFF;
    #1;
    n_vec++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL single_ready_cool: got %b want %b", ready, 4'b0000); end
    @(negedge clock);
    #1;
    n_vec++; if (ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready2: got %b want %b", ready, 4'b0001); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_idle2: got %b want 0", busy); end
    @(negedge clock);
    valid = '0;
    @(negedge clock);
    #1;
    n_vec++; if (q !== 8'h0F) begin n_bad++; $display("FAIL single_q2: got %h want %h", q, 8'h0F); end
  endtask

  // Move ptr to 2 with req1, then req3 and req1 compete: req3 first, req1 next.
  task automatic test_wrap_skip();
    @(negedge clock);
    valid = 4'b0010; j = '0; k = '0; sr = 1'b0;
    #1;
    n_vec++; if (ready !== 4'b0010) begin n_bad++; $display("FAIL wrap_ready_pre: got %b want %b", ready, 4'b0010); end
    @(negedge clock);
    valid = '0;
    repeat (2) @(negedge clock);
    valid = 4'b1010;
    #1;
    n_vec++; if (ready !== 4'b1000) begin n_bad++; $display("FAIL wrap_ready_first: got %b want %b", ready, 4'b1000); end
    @(negedge clock);
    valid = 4'b0010;
    #1;
    n_vec++; if (gid !== 2'd3) begin n_bad++; $display("FAIL wrap_gid_first: got %0d want 3", gid); end
    n_vec++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL wrap_ready_apply: got %b want %b", ready, 4'b0000); end
    @(negedge clock);
    #1;
    n_vec++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL wrap_ready_cool: got %b want %b", ready, 4'b0000); end
    @(negedge clock);
    #1;
    n_vec++; if (ready !== 4'b0010) begin n_bad++; $display("FAIL wrap_ready_second: got %b want %b", ready, 4'b0010); end
    @(negedge clock);
    valid = '0;
    #1;
    n_vec++; if (gid !== 2'd1) begin n_bad++; $display("FAIL wrap_gid_second: got %0d want 1", gid); end
    @(negedge clock);
    #1;
    n_vec++; if (q !== 8'h0F) begin n_bad++; $display("FAIL wrap_q_hold: got %h want %h", q, 8'h0F); end
  endtask

  // req2 sets every bit, then reset is asserted in the COOL cycle.
  task automatic test_reset_mid_cool();
    @(negedge clock);
    valid = 4'b0100; j[23:16] = 8'hFF; k[23:16] = 8'h00;
    #1;
    n_vec++; if (ready !== 4'b0100) begin n_bad++; $display("FAIL mid_ready: got %b want %b", ready, 4'b0100); end
    @(negedge clock);
    valid = '0;
    @(negedge clock);
    #1;
    n_vec++; if (q !== 8'hFF) begin n_bad++; $display("FAIL mid_q_set: got %h want %h", q, 8'hFF); end
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_cool: got %b want 1", busy); end
    rst = 1'b0;
    valid = 4'hF;
    #1;
    n_vec++; if (q !== 8'h00) begin n_bad++; $display("FAIL mid_rst_q: got %h want %h", q, 8'h00); end
    n_vec++; if (qb !== 8'hFF) begin n_bad++; $display("FAIL mid_rst_qbar: got %h want %h", qb, 8'hFF); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    n_vec++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_ready: got %b want %b", ready, 4'b0000); end
    n_vec++; if (gid !== 2'd0) begin n_bad++; $display("FAIL mid_rst_gid: got %0d want 0", gid); end
    @(negedge clock);
    #1;
    n_vec++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_ready_hold: got %b want %b", ready, 4'b0000); end
    rst = 1'b1;
    #1;
    n_vec++; if (ready !== 4'b0001) begin n_bad++; $display("FAIL mid_ptr_zero: got %b want %b", ready, 4'b0001); end
    valid = '0;
  endtask

  // All four valid continuously; requester i toggles bit i so a repeat or a miss shows in q.
  task automatic test_round_robin();
    logic [7:0] exp_q;
    logic [1:0] g;
    exp_q = 8'h00;
    @(negedge clock);
    j = '0; k = '0; sr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      j[i*8 +: 8] = 8'(1) << i;
      k[i*8 +: 8] = 8'(1) << i;
    end
    valid = 4'hF;
    #1;
    for (int n = 0; n < 5; n++) begin
      g = 2'(n % 4);
      n_vec++; if (ready !== (4'(1) << g)) begin n_bad++; $display("FAIL rr_ready_%0d: got %b want %b", n, ready, 4'(1) << g); end
      @(negedge clock);
      #1;
      n_vec++; if (gid !== g) begin n_bad++; $display("FAIL rr_gid_%0d: got %0d want %0d", n, gid, g); end
      n_vec++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL rr_ready_apply_%0d: got %b want 0000", n, ready); end
      @(negedge clock);
      #1;
      exp_q = exp_q ^ (8'(1) << g);
      n_vec++; if (q !== exp_q) begin n_bad++; $display("FAIL rr_q_%0d: got %h want %h", n, q, exp_q); end
      n_vec++; if (ready !== 4'b0000) begin n_bad++; $display("FAIL rr_ready_cool_%0d: got %b want 0000", n, ready); end
      @(negedge clock);
      #1;
    end
    valid = '0;
  endtask

  // COOL=0: two requesters alternate, one accept every 2 cycles.
  task automatic test_back_to_back();
    logic [7:0] exp_q;
    logic [1:0] g;
    exp_q = 8'h00;
    @(negedge clock);
    j0 = '0; k0 = '0; sr0 = 1'b0;
    j0[7:0] = 8'h01; k0[7:0] = 8'h01;
    j0[15:8] = 8'h02; k0[15:8] = 8'h02;
    valid0 = 4'b0011;
    #1;
    for (int n = 0; n < 4; n++) begin
      g = 2'(n % 2);
      n_vec++; if (ready0 !== (4'(1) << g)) begin n_bad++; $display("FAIL b2b_ready_%0d: got %b want %b", n, ready0, 4'(1) << g); end
      n_vec++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_idle_%0d: got %b want 0", n, busy0); end
      @(negedge clock);
      #1;
      n_vec++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_apply_%0d: got %b want 1", n, busy0); end
      n_vec++; if (gid0 !== g) begin n_bad++; $display("FAIL b2b_gid_%0d: got %0d want %0d", n, gid0, g); end
      @(negedge clock);
      #1;
      exp_q = exp_q ^ (8'(1) << g);
      n_vec++; if (q0 !== exp_q) begin n_bad++; $display("FAIL b2b_q_%0d: got %h want %h", n, q0, exp_q); end
      n_vec++; if (qb0 !== ~exp_q) begin n_bad++; $display("FAIL b2b_qbar_%0d: got %h want %h", n, qb0, ~exp_q); end
    end
    valid0 = '0;
    #1;
    n_vec++; if (ready0 !== 4'b0000) begin n_bad++; $display("FAIL b2b_ready_end: got %b want 0000", ready0); end
    @(negedge clock);
    #1;
    n_vec++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end: got %b want 0", busy0); end
  endtask

  // SR command with S=R=1 on bit 0 from req1 (ptr is 1, q is 0E here).
  task automatic test_sr_guard();
    logic [7:0] exp_q;
    logic       exp_err;
`ifdef JK_SR_GUARD_EN
    exp_q = 8'h0E; exp_err = 1'b1;
`else
    exp_q = 8'h0F; exp_err = 1'b0;
`endif
    @(negedge clock);
    j = '0; k = '0;
    j[15:8] = 8'h01; k[15:8] = 8'h01; sr = 1'b1;
    valid = 4'b0010;
    #1;
    n_vec++; if (ready !== 4'b0010) begin n_bad++; $display("FAIL guard_ready: got %b want %b", ready, 4'b0010); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL guard_err_idle: got %b want 0", err); end
    @(negedge clock);
    valid = '0; sr = 1'b0;
    #1;
    n_vec++; if (err !== exp_err) begin n_bad++; $display("FAIL guard_err_apply: got %b want %b", err, exp_err); end
    @(negedge clock);
    #1;
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL guard_err_after: got %b want 0", err); end
    n_vec++; if (q !== exp_q) begin n_bad++; $display("FAIL guard_q: got %h want %h", q, exp_q); end
    n_vec++; if (qb !== ~exp_q) begin n_bad++; $display("FAIL guard_qbar: got %h want %h", qb, ~exp_q); end
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_skip();
    test_reset_mid_cool();
    test_round_robin();
    test_back_to_back();
    test_sr_guard();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
